// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases NUM_DOMAINS active-low resets in order after an initial delay,
// spaced by a step delay. Optional build macro RST_SEQ_ORDERED_ASSERT_EN adds ordered re-assertion.
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS = 4,
  parameter int INIT_DELAY  = 32,
  parameter int STEP_DELAY  = 16,
  localparam int SW = $clog2(NUM_DOMAINS + 1)
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic                   sw_rst_req_i,
  input  logic                   hold_i,
  output logic [NUM_DOMAINS-1:0] rst_no,
  output logic [SW-1:0]          stage_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int MAXD = (INIT_DELAY > STEP_DELAY) ? INIT_DELAY : STEP_DELAY;
  localparam int CW   = $clog2(MAXD + 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_DELAY - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_DELAY - 1);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_STEP   = 2'd1,
`ifdef RST_SEQ_ORDERED_ASSERT_EN
    ST_DONE   = 2'd2,
    ST_ASSERT = 2'd3
`else
    ST_DONE   = 2'd2
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          stage_q, stage_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] rst_d;
  logic                   busy_d, done_d;

  // Domain k is out of reset exactly when more than k domains have been released.
  function automatic logic [NUM_DOMAINS-1:0] therm(input logic [SW-1:0] s);
    logic [NUM_DOMAINS-1:0] t;
    t = '0;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      t[k] = (k < int'(s));
    end
    return t;
  endfunction

  // Next-state, stage and shared delay counter.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (!hold_i && (cnt_q == INIT_LAST)) begin
          cnt_d   = '0;
          stage_d = SW'(1);
          if (NUM_DOMAINS == 1) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_STEP;
          end
        end else if (!hold_i) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_STEP: begin
        if (!hold_i && (cnt_q == STEP_LAST)) begin
          cnt_d   = '0;
          stage_d = stage_q + SW'(1);
          if (stage_q == SW'(NUM_DOMAINS - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_STEP;
          end
        end else if (!hold_i) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DONE: begin
        cnt_d = '0;
        if (sw_rst_req_i) begin
`ifdef RST_SEQ_ORDERED_ASSERT_EN
          stage_d = stage_q - SW'(1);
          if (stage_q == SW'(1)) begin
            state_d = ST_INIT;
          end else begin
            state_d = ST_ASSERT;
          end
`else
          stage_d = '0;
          state_d = ST_INIT;
`endif
        end else begin
          state_d = ST_DONE;
        end
      end
`ifdef RST_SEQ_ORDERED_ASSERT_EN
      ST_ASSERT: begin
        if (!hold_i && (cnt_q == STEP_LAST)) begin
          cnt_d   = '0;
          stage_d = stage_q - SW'(1);
          if (stage_q == SW'(1)) begin
            state_d = ST_INIT;
          end else begin
            state_d = ST_ASSERT;
          end
        end else if (!hold_i) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
`endif
      default: begin
        state_d = ST_INIT;
        stage_d = '0;
        cnt_d   = '0;
      end
    endcase
    rst_d  = therm(stage_d);
    busy_d = (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs; arst_ni asserts every domain at once.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ST_INIT;
      stage_q <= '0;
      cnt_q   <= '0;
      rst_no  <= '0;
      stage_o <= '0;
      busy_o  <= 1'b1;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      rst_no  <= rst_d;
      stage_o <= stage_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

endmodule
